// File: rtl/adc_multi_controller.sv
// Multi-channel ADC sequencer: starts conversions on a shared mclk, waits for
// the wired-OR busy to drop, clocks all sdo lines in parallel on a shared
// sclk and optionally sums n+1 conversions per channel.
module adc_multi_controller #(
  parameter int DATA_WIDTH   = 20,
  parameter int NUM_CH       = 2,
  parameter int ACC_WIDTH    = 36,   // must be >= DATA_WIDTH+16
  parameter int MCLK_CYCLES  = 2,
  parameter int SCLK_DIV     = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           go,
  input  logic                           avg_en,
  input  logic [15:0]                    n,
  output logic                           ready,
  output logic                           done,
  output logic                           error,
  output logic [NUM_CH*ACC_WIDTH-1:0]    data,
  output logic                           mclk,
  input  logic                           busy,
  output logic                           sclk,
  input  logic [NUM_CH-1:0]              sdo
);

  typedef enum logic [2:0] {IDLE, CONVERT, WAIT_BUSY, READ, ACCUM, DONE} state_t;

  localparam int TMAX = (MCLK_CYCLES > BUSY_TIMEOUT) ? MCLK_CYCLES : BUSY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int HW   = $clog2(SCLK_DIV + 1);
  localparam int BW   = $clog2(DATA_WIDTH + 1);

  state_t                               state, state_nxt;
  logic [TW-1:0]                        tmr;      // cycles spent in CONVERT / WAIT_BUSY
  logic [HW-1:0]                        hc;       // position inside an sclk half-period
  logic                                 hi;       // current sclk half (1 = high)
  logic [BW-1:0]                        bc;       // sclk period index
  logic                                 avg_q;
  logic [15:0]                          n_q;
  logic [16:0]                          cnt;      // completed conversions
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    shreg;
  logic [NUM_CH-1:0][ACC_WIDTH-1:0]     acc, acc_nxt;

  logic mclk_end, busy_ok, busy_to, half_end, bit_rise, read_end, last_conv;

  assign mclk_end  = tmr == TW'(MCLK_CYCLES - 1);
  assign busy_ok   = (tmr != '0) && !busy;          // first WAIT_BUSY cycle ignores busy
  assign busy_to   = busy && (tmr >= TW'(BUSY_TIMEOUT));
  assign half_end  = hc == HW'(SCLK_DIV - 1);
  assign bit_rise  = !hi && half_end;               // sclk goes 0->1 on this edge
  assign read_end  = hi && half_end && (bc == BW'(DATA_WIDTH - 1));
  // The ACCUM now in progress completes conversion cnt+1; stop once that is n+1.
  assign last_conv = !avg_q || (cnt == {1'b0, n_q});

  assign ready = state == IDLE;
  assign mclk  = state == CONVERT;
  assign sclk  = (state == READ) && hi;
  assign done  = state == DONE;
  assign error = (state == WAIT_BUSY) && busy_to;

  // Per-channel sum with the sample sign-extended to the accumulator width.
  always_comb begin
    acc_nxt = acc;
    for (int k = 0; k < NUM_CH; k++)
      acc_nxt[k] = acc[k] + {{(ACC_WIDTH-DATA_WIDTH){shreg[k][DATA_WIDTH-1]}}, shreg[k]};
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (go) state_nxt = CONVERT;
      CONVERT:   if (mclk_end) state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (busy_ok) state_nxt = READ;
                 else if (busy_to) state_nxt = IDLE;
      READ:      if (read_end) state_nxt = ACCUM;
      ACCUM:     state_nxt = last_conv ? DONE : CONVERT;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register, sequencing counters and datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tmr   <= '0;
      hc    <= '0;
      hi    <= 1'b0;
      bc    <= '0;
      avg_q <= 1'b0;
      n_q   <= '0;
      cnt   <= '0;
      shreg <= '0;
      acc   <= '0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= (state_nxt == state && (state == CONVERT || state == WAIT_BUSY)) ? tmr + 1'b1 : '0;
      case (state)
        IDLE: if (go) begin
          avg_q <= avg_en;
          n_q   <= n;
          cnt   <= '0;
          acc   <= '0;
        end
        READ: begin
          hc <= half_end ? '0 : hc + 1'b1;
          if (half_end) hi <= !hi;
          if (read_end) bc <= '0;
          else if (hi && half_end) bc <= bc + 1'b1;
          if (bit_rise)
            for (int k = 0; k < NUM_CH; k++)
              shreg[k] <= {shreg[k][DATA_WIDTH-2:0], sdo[k]};
        end
        ACCUM: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          // Output register is loaded on entry to DONE so data is valid with done.
          if (last_conv) data <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
